seq_lock_ctrl: RTL and testbench

- Parametrised combination-lock controller.
- Successor to the fixed 4-button, 4-key lock / down-counter pair.
- Adds:
  - configurable key count and code length
  - a runtime-loadable code
  - an entry timeout driven by an external 1 Hz tick
  - a failed-attempt counter with a timed alarm lockout.
- Sits between the pulse generator / pushbutton inputs and the LED-graph / 7-segment display path.

---
 rtl/seq_lock_ctrl_if.sv | 42 ++++
 rtl/seq_lock_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seq_lock_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_lock_ctrl_if.sv
// Keypad-side and display-side signals of the combination-lock controller.
// master drives keys, tick and code; slave is the controller itself.
interface seq_lock_ctrl_if #(
    parameter int N_KEYS   = 4,
    parameter int CODE_LEN = 4,
    parameter int CNT_W    = 4,
    parameter int MAX_FAIL = 3
);
    localparam int DW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic                     tick_1hz;
    logic [N_KEYS-1:0]        key_in;
    logic [CODE_LEN*DW-1:0]   code_in;
    logic [CNT_W-1:0]         countdown;
    logic [CODE_LEN-1:0]      progress;
    logic                     unlocked;
    logic                     alarm;
    logic [FW-1:0]            fail_cnt;

    modport master (
        output tick_1hz,
        output key_in,
        output code_in,
        input  countdown,
        input  progress,
        input  unlocked,
        input  alarm,
        input  fail_cnt
    );

    modport slave (
        input  tick_1hz,
        input  key_in,
        input  code_in,
        output countdown,
        output progress,
        output unlocked,
        output alarm,
        output fail_cnt
    );
endinterface

// File: rtl/seq_lock_ctrl.sv
// Combination-lock controller: keyed entry with timeout, runtime code,
// failed-attempt counting and a timed alarm lockout.
module seq_lock_ctrl #(
    parameter int N_KEYS   = 4,
    parameter int CODE_LEN = 4,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 9,
    parameter int LOCKOUT  = 15,
    parameter int MAX_FAIL = 3
) (
    input  logic MCLK,
    input  logic RESET,
    seq_lock_ctrl_if.slave bus
);
    localparam int DW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int IW = $clog2(CODE_LEN + 1);

    localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_LOAD = CNT_W'(LOCKOUT);
    localparam logic [FW-1:0]    F_MAX  = FW'(MAX_FAIL);
    localparam logic [IW-1:0]    I_LAST = IW'(CODE_LEN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_FAIL    = 3'd2;
    localparam logic [2:0] S_UNLOCK  = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    logic [2:0]          state, state_n;
    logic [N_KEYS-1:0]   key_prev;
    logic [IW-1:0]       idx, idx_n;
    logic                mismatch, mismatch_n;
    logic [CNT_W-1:0]    countdown_q, countdown_n;
    logic [CODE_LEN-1:0] progress_q, progress_n;
    logic                unlocked_q, unlocked_n;
    logic                alarm_q, alarm_n;
    logic [FW-1:0]       fail_q, fail_n;

    logic [N_KEYS-1:0]   rise;
    logic                press;
    logic [DW-1:0]       key_val;
    logic [DW-1:0]       digit;
    logic                bad_digit;
    logic                mis_acc;
    logic                last;
    logic                taking;
    logic [CNT_W-1:0]    cd_dec;
    logic [FW-1:0]       fail_inc;

    assign rise  = bus.key_in & ~key_prev;
    assign press = |rise;
    assign last  = (idx == I_LAST);

    always_comb begin
        key_val = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (rise[i]) key_val = DW'(i);
        end
    end

    // Digit under comparison comes from code_in as seen this cycle.
    always_comb begin
        digit = '0;
        for (int j = 0; j < CODE_LEN; j++) begin
            if (idx == IW'(j)) digit = bus.code_in[j*DW +: DW];
        end
    end

    assign bad_digit = !$onehot(rise) || (key_val != digit);
    assign taking    = (state == S_IDLE) || (state == S_ENTRY);
    assign mis_acc   = ((state == S_ENTRY) && mismatch) || bad_digit;
    assign cd_dec    = (countdown_q == '0) ? '0 : countdown_q - CNT_W'(1);
    assign fail_inc  = (fail_q == F_MAX) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        mismatch_n  = mismatch;
        countdown_n = countdown_q;
        progress_n  = progress_q;
        unlocked_n  = unlocked_q;
        alarm_n     = alarm_q;
        fail_n      = fail_q;

        unique case (state)
            S_IDLE: begin
                countdown_n = T_LOAD;
                if (press) state_n = S_ENTRY;
            end
            S_ENTRY: begin
                if (bus.tick_1hz) begin
                    countdown_n = cd_dec;
                    if (countdown_q == '0) state_n = S_FAIL;
                end
            end
            S_FAIL: begin
                fail_n     = fail_inc;
                progress_n = '0;
                idx_n      = '0;
                mismatch_n = 1'b0;
                if (fail_inc == F_MAX) begin
                    state_n     = S_LOCKOUT;
                    countdown_n = L_LOAD;
                    alarm_n     = 1'b1;
                end else begin
                    state_n     = S_IDLE;
                    countdown_n = T_LOAD;
                end
            end
            S_UNLOCK: begin
                if (press) begin
                    state_n     = S_IDLE;
                    unlocked_n  = 1'b0;
                    progress_n  = '0;
                    idx_n       = '0;
                    mismatch_n  = 1'b0;
                    countdown_n = T_LOAD;
                end
            end
            S_LOCKOUT: begin
                if (bus.tick_1hz) begin
                    if (countdown_q == '0) begin
                        state_n     = S_IDLE;
                        alarm_n     = 1'b0;
                        fail_n      = '0;
                        countdown_n = T_LOAD;
                    end else begin
                        countdown_n = cd_dec;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A digit press overrides a same-cycle timeout when it completes.
        if (taking && press) begin
            progress_n = CODE_LEN'({progress_q, 1'b1});
            idx_n      = idx + IW'(1);
            mismatch_n = mis_acc;
            if (last) begin
                if (mis_acc) begin
                    state_n = S_FAIL;
                end else begin
                    state_n    = S_UNLOCK;
                    unlocked_n = 1'b1;
                    fail_n     = '0;
                end
            end
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            key_prev    <= '0;
            idx         <= '0;
            mismatch    <= 1'b0;
            countdown_q <= T_LOAD;
            progress_q  <= '0;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            fail_q      <= '0;
        end else begin
            state       <= state_n;
            key_prev    <= bus.key_in;
            idx         <= idx_n;
            mismatch    <= mismatch_n;
            countdown_q <= countdown_n;
            progress_q  <= progress_n;
            unlocked_q  <= unlocked_n;
            alarm_q     <= alarm_n;
            fail_q      <= fail_n;
        end
    end

    assign bus.countdown = countdown_q;
    assign bus.progress  = progress_q;
    assign bus.unlocked  = unlocked_q;
    assign bus.alarm     = alarm_q;
    assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Scoreboard bench for seq_lock_ctrl: a queue-based attempt model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_seq_lock_ctrl;
    localparam int TIMEOUT  = 9;
    localparam int LOCKOUT  = 15;
    localparam int MAX_FAIL = 3;
    localparam int CODE_LEN = 4;

    logic MCLK = 1'b0;
    logic RESET = 1'b1;

    seq_lock_ctrl_if bus ();

    seq_lock_ctrl dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int cd;
        int prog;
        bit unl;
        bit alm;
        int fail;
    } exp_t;

    typedef enum {M_IDLE, M_ENTRY, M_FAIL, M_OPEN, M_ALARM} mmode_t;

    exp_t   exp_q[$];
    int     total = 0;
    int     bad = 0;
    logic [7:0] code = 8'h87;

    mmode_t mode;
    bit     ok_q[$];
    int     m_cd;
    int     m_fail;
    logic [3:0] m_prev;

    function automatic int digit_of(logic [7:0] c, int i);
        logic [7:0] s;
        s = c >> (2 * i);
        return int'(s[1:0]);
    endfunction

    function automatic void model_reset();
        mode   = M_IDLE;
        ok_q.delete();
        m_cd   = TIMEOUT;
        m_fail = 0;
        m_prev = '0;
    endfunction

    function automatic void step(logic [3:0] keys, bit tick, logic [7:0] c);
        logic [3:0] rise;
        bit pr, good, entered, to, all_ok;
        rise    = keys & ~m_prev;
        m_prev  = keys;
        pr      = (rise != 0);
        good    = 0;
        entered = 0;
        if (pr && $countones(rise) == 1)
            good = ($clog2(rise) == digit_of(c, ok_q.size()));
        case (mode)
            M_IDLE: begin
                m_cd = TIMEOUT;
                if (pr) begin
                    mode = M_ENTRY;
                    ok_q.push_back(good);
                    entered = 1;
                end
            end
            M_ENTRY: begin
                to = tick && (m_cd == 0);
                if (tick && m_cd > 0) m_cd--;
                if (pr) begin
                    ok_q.push_back(good);
                    entered = 1;
                end
                if (to) mode = M_FAIL;
            end
            M_FAIL: begin
                ok_q.delete();
                if (m_fail < MAX_FAIL) m_fail++;
                if (m_fail == MAX_FAIL) begin
                    mode = M_ALARM;
                    m_cd = LOCKOUT;
                end else begin
                    mode = M_IDLE;
                    m_cd = TIMEOUT;
                end
            end
            M_OPEN: begin
                if (pr) begin
                    mode = M_IDLE;
                    ok_q.delete();
                    m_cd = TIMEOUT;
                end
            end
            M_ALARM: begin
                if (tick) begin
                    if (m_cd == 0) begin
                        mode   = M_IDLE;
                        m_fail = 0;
                        m_cd   = TIMEOUT;
                    end else begin
                        m_cd--;
                    end
                end
            end
            default: ;
        endcase
        if (entered && ok_q.size() == CODE_LEN) begin
            all_ok = 1;
            foreach (ok_q[i]) if (!ok_q[i]) all_ok = 0;
            if (all_ok) begin
                mode   = M_OPEN;
                m_fail = 0;
            end else begin
                mode = M_FAIL;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.cd   = m_cd;
        e.prog = (1 << ok_q.size()) - 1;
        e.unl  = (mode == M_OPEN);
        e.alm  = (mode == M_ALARM);
        e.fail = m_fail;
        return e;
    endfunction

    task automatic cyc(input logic [3:0] k, input bit t);
        @(negedge MCLK);
        bus.key_in   = k;
        bus.tick_1hz = t;
        bus.code_in  = code;
        step(k, t, code);
        exp_q.push_back(model_out());
    endtask

    task automatic press(input int k, input bit t);
        logic [3:0] v;
        v = 4'(1) << k;
        cyc(v, t);
        cyc(4'd0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(4'd0, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        total++;
        if (bus.countdown !== 4'(TIMEOUT) || bus.progress !== 4'd0 ||
            bus.unlocked !== 1'b0 || bus.alarm !== 1'b0 ||
            bus.fail_cnt !== 2'd0) begin
            bad++;
            $display("FAIL %s: got cd=%0d prog=%b unl=%b alm=%b fail=%0d want cd=%0d rest 0",
                     tag, bus.countdown, bus.progress, bus.unlocked,
                     bus.alarm, bus.fail_cnt, TIMEOUT);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge MCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (int'(bus.countdown) != e.cd || int'(bus.progress) != e.prog ||
                    bus.unlocked !== e.unl || bus.alarm !== e.alm ||
                    int'(bus.fail_cnt) != e.fail) begin
                    bad++;
                    $display("FAIL outputs @%0t: got cd=%0d prog=%b unl=%b alm=%b fail=%0d want cd=%0d prog=%b unl=%b alm=%b fail=%0d",
                             $time, bus.countdown, bus.progress, bus.unlocked,
                             bus.alarm, bus.fail_cnt, e.cd, 4'(e.prog),
                             e.unl, e.alm, e.fail);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int r;
        bus.key_in   = '0;
        bus.tick_1hz = 1'b0;
        bus.code_in  = code;
        model_reset();
        #8;
        chk_reset("reset_state");
        #4;
        RESET = 1'b0;

        // Correct entry, then relock
        press(3, 0); press(1, 0); press(0, 0); press(2, 0);
        cyc(4'd0, 0);
        press(0, 0);

        // Wrong second digit
        press(3, 0); press(2, 0); press(0, 0); press(2, 0);
        cyc(4'd0, 0);

        // Timeout after one digit
        press(3, 0);
        ticks(10);
        cyc(4'd0, 0);

        // Completing press wins over a tick at countdown 1
        press(3, 0);
        ticks(8);
        press(1, 0); press(0, 0);
        press(2, 1);
        press(0, 0);

        // Three wrong entries into lockout
        repeat (3) begin
            press(0, 0); press(0, 0); press(0, 0); press(0, 0);
            cyc(4'd0, 0);
        end
        press(3, 0); press(1, 0);
        ticks(16);
        cyc(4'd0, 0);

        // Multi-key rise as first digit
        cyc(4'b0011, 0); cyc(4'd0, 0);
        press(1, 0); press(0, 0); press(2, 0);
        cyc(4'd0, 0);

        // Asynchronous reset mid-entry, key held through release
        press(3, 0); press(1, 0);
        @(posedge MCLK);
        #2;
        RESET = 1'b1;
        bus.tick_1hz = 1'b0;
        #1;
        chk_reset("async_reset");
        model_reset();
        bus.key_in = 4'b1000;
        #1;
        RESET = 1'b0;
        cyc(4'b1000, 0);
        cyc(4'd0, 0);
        press(1, 0); press(0, 0); press(2, 0);
        press(1, 0);

        // Randomised traffic
        repeat (80) begin
            r = $urandom_range(0, 4);
            case (r)
                0: for (int d = 0; d < CODE_LEN; d++)
                       press(digit_of(code, d), $urandom_range(0, 3) == 0);
                1: repeat (6)
                       cyc(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
                2: ticks($urandom_range(1, 12));
                3: begin
                       code = 8'($urandom);
                       cyc(4'd0, 0);
                   end
                default: press($urandom_range(0, 3), $urandom_range(0, 1) == 1);
            endcase
        end
        cyc(4'd0, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge MCLK);
        #2;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
